// File: rtl/pool_unit.sv
// pool_unit: streaming 2x2 / stride-2 max-pooling stage.
// Consumes one signed activation per valid beat in row-major order and
// emits one registered maximum per 2x2 window. Horizontal pairs are reduced
// as they arrive; even-row pair maxima wait in a line buffer until the
// matching odd-row pair shows up.
// Handshake: relu_valid_i qualifies relu_data_i for one cycle and there is
// no backpressure, so every valid beat is consumed on the rising edge;
// pool_valid_o is a one-cycle pulse qualifying pool_data_o.
module pool_unit #(
  parameter int FW = 16,
  parameter int IW = 224,
  parameter int IH = 224
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] relu_data_i,
  input  logic          relu_valid_i,
  output logic [FW-1:0] pool_data_o,
  output logic          pool_valid_o,
  output logic          frame_done_o
);

  localparam int CW = $clog2(IW);
  localparam int RW = $clog2(IH);
  localparam int LD = IW / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic signed [FW-1:0] pair_q, pair_d;
  logic signed [FW-1:0] line_buf_q [LD];
  logic [FW-1:0]        pool_data_q, pool_data_d;
  logic                 pool_valid_q, pool_valid_d;
  logic                 frame_done_q, frame_done_d;

  logic signed [FW-1:0] data_s;
  logic signed [FW-1:0] lb_rd;
  logic signed [FW-1:0] h_max;
  logic signed [FW-1:0] w_max;
  logic [LW-1:0]        lb_idx;
  logic                 last_col, last_row;
  logic                 lb_we;
  logic                 fire;

  // Window datapath: horizontal pair max, then vertical max against the buffer.
  always_comb begin
    data_s   = $signed(relu_data_i);
    lb_idx   = LW'(col_q >> 1);
    lb_rd    = line_buf_q[lb_idx];
    h_max    = (pair_q > data_s) ? pair_q : data_s;
    w_max    = (lb_rd > h_max) ? lb_rd : h_max;
    last_col = (col_q == CW'(IW - 1));
    last_row = (row_q == RW'(IH - 1));
    lb_we    = relu_valid_i & col_q[0] & ~row_q[0];
    fire     = relu_valid_i & col_q[0] & row_q[0];
  end

  // Next-state for position counters, pair register and output registers.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    pool_data_d  = pool_data_q;
    pool_valid_d = fire;
    frame_done_d = fire & last_col & last_row;
    if (relu_valid_i) begin
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + RW'(1);
      end
      if (!col_q[0]) begin
        pair_d = data_s;
      end
    end
    if (fire) begin
      pool_data_d = w_max;
    end
  end

  // Control and output state; reset abandons any partial map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      pool_data_q  <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      pool_data_q  <= pool_data_d;
      pool_valid_q <= pool_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer holds even-row pair maxima; every entry is rewritten before use.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf_q[lb_idx] <= h_max;
    end
  end

  assign pool_data_o  = pool_data_q;
  assign pool_valid_o = pool_valid_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_pool_unit.sv
// tb_pool_unit: randomized and directed bench for pool_unit.
// DUT "a" is a 4x4 map checked cycle by cycle against a 2-D window model;
// DUT "b" is a 2x2 map checked with a short directed sequence.
module tb_pool_unit;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic        clk;
  logic        rst;
  logic [15:0] a_data;
  logic        a_valid;
  logic [15:0] a_pool_data;
  logic        a_pool_valid;
  logic        a_frame_done;
  logic [15:0] b_data;
  logic        b_valid;
  logic [15:0] b_pool_data;
  logic        b_pool_valid;
  logic        b_frame_done;

  int tests_run;
  int tests_failed;

  pool_unit #(.FW(16), .IW(W), .IH(H)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .relu_data_i  (a_data),
    .relu_valid_i (a_valid),
    .pool_data_o  (a_pool_data),
    .pool_valid_o (a_pool_valid),
    .frame_done_o (a_frame_done)
  );

  pool_unit #(.FW(16), .IW(2), .IH(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .relu_data_i  (b_data),
    .relu_valid_i (b_valid),
    .pool_data_o  (b_pool_data),
    .pool_valid_o (b_pool_valid),
    .frame_done_o (b_frame_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the whole current map as a 2-D picture and, when the bottom-right
  // pixel of a 2x2 window arrives, predicts the max of that window.
  logic signed [15:0] frame [NP];
  int                 pix_n;
  logic [16:0]        exp_q[$];
  logic               exp_fire;
  logic [15:0]        exp_held;
  logic [15:0]        got_q[$];
  logic               got_done_q[$];

  function automatic logic signed [15:0] smax(input logic signed [15:0] x, input logic signed [15:0] y);
    return (x > y) ? x : y;
  endfunction

  task automatic model_beat(input logic [15:0] d);
    int r;
    int c;
    logic signed [15:0] m;
    frame[pix_n] = d;
    r = pix_n / W;
    c = pix_n % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      m = smax(smax(frame[(r-1)*W + c-1], frame[(r-1)*W + c]),
               smax(frame[r*W + c-1], frame[r*W + c]));
      exp_q.push_back({(pix_n == NP - 1), m});
      exp_fire = 1'b1;
      exp_held = m;
    end
    pix_n = (pix_n + 1) % NP;
  endtask

  // Scoreboard: model on each edge, compare DUT a just after the edge.
  initial begin
    logic [16:0] e;
    pix_n    = 0;
    exp_fire = 1'b0;
    exp_held = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pix_n    = 0;
        exp_fire = 1'b0;
        exp_held = '0;
        exp_q.delete();
        got_q.delete();
        got_done_q.delete();
      end else begin
        exp_fire = 1'b0;
        if (a_valid) model_beat(a_data);
      end
      #1;
      check("a_valid", {31'd0, a_pool_valid}, {31'd0, exp_fire});
      if (a_pool_valid) begin
        got_q.push_back(a_pool_data);
        got_done_q.push_back(a_frame_done);
      end
      if (exp_fire && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_data", {16'd0, a_pool_data}, {16'd0, e[15:0]});
        check("a_done", {31'd0, a_frame_done}, {31'd0, e[16]});
      end else begin
        check("a_data_hold", {16'd0, a_pool_data}, {16'd0, exp_held});
        check("a_done_idle", {31'd0, a_frame_done}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_valid = 1'b0;
      a_data  = 16'($urandom);
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input int gap_pct);
    int gaps;
    gaps = 0;
    while (gaps < 8 && $urandom_range(0, 99) < gap_pct) begin
      idle(1);
      gaps++;
    end
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = d;
  endtask

  // Compare the outputs collected since the last reset/clear with a list.
  task automatic expect_list(input string tag, input int n, input logic [15:0] vals [8], input logic [7:0] dones);
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check({tag, "_val"}, {16'd0, got_q[i]}, {16'd0, vals[i]});
      check({tag, "_done"}, {31'd0, got_done_q[i]}, {31'd0, dones[i]});
    end
    got_q.delete();
    got_done_q.delete();
  endtask

  logic [15:0] list_a [8];
  logic [15:0] list_b [8];
  logic [15:0] list_c [8];
  logic [15:0] b_vals [4];
  logic [15:0] sgn_map [NP];

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;
    list_a  = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0};
    list_b  = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd15, 16'd13, 16'd7, 16'd5};
    list_c  = '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    b_vals  = '{16'd9, 16'd3, 16'd4, 16'd8};
    for (int i = 0; i < NP; i++) sgn_map[i] = '0;
    sgn_map[0] = 16'hFFFF;
    sgn_map[1] = 16'hFFFD;
    sgn_map[4] = 16'hFFF9;
    sgn_map[5] = 16'hFFFE;

    repeat (3) @(negedge clk);
    check("rst_a_data", {16'd0, a_pool_data}, 32'd0);
    check("rst_a_valid", {31'd0, a_pool_valid}, 32'd0);
    check("rst_a_done", {31'd0, a_frame_done}, 32'd0);
    check("rst_b_valid", {31'd0, b_pool_valid}, 32'd0);
    rst = 1'b0;
    idle(2);

    // 0..15 continuous
    for (int i = 0; i < NP; i++) send_beat(16'(i), 0);
    idle(3);
    expect_list("seq", 4, list_a, 8'b0000_1000);

    // same picture with ~50% gaps
    for (int i = 0; i < NP; i++) send_beat(16'(i), 50);
    idle(3);
    expect_list("gap", 4, list_a, 8'b0000_1000);

    // one all-negative window exercises the signed compare
    for (int i = 0; i < NP; i++) send_beat(sgn_map[i], 20);
    idle(3);
    expect_list("signed", 4, list_c, 8'b0000_1000);

    // two maps back to back, no idle between them
    for (int i = 0; i < NP; i++) send_beat(16'(i), 0);
    for (int i = 0; i < NP; i++) send_beat(16'(NP - 1 - i), 0);
    idle(3);
    expect_list("b2b", 8, list_b, 8'b1000_1000);

    // reset after 6 beats, valid held high during reset, then a clean map
    for (int i = 0; i < 6; i++) send_beat(16'(i + 100), 0);
    @(negedge clk);
    rst     = 1'b1;
    a_valid = 1'b1;
    a_data  = 16'h7FFF;
    @(negedge clk);
    a_data  = 16'h7FFE;
    @(negedge clk);
    rst     = 1'b0;
    a_valid = 1'b0;
    for (int i = 0; i < NP; i++) send_beat(16'(i), 0);
    idle(3);
    expect_list("rst_mid", 4, list_a, 8'b0000_1000);

    // randomized maps with random gaps, model-checked every cycle
    for (int m = 0; m < 8; m++) begin
      for (int i = 0; i < NP; i++) send_beat(16'($urandom), (m % 2 == 0) ? 0 : 40);
    end
    idle(3);

    // 2x2 instance: 9,3,4,8 -> single output 9 with frame done
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_data  = b_vals[i];
      @(posedge clk);
      #2;
      check("b_valid", {31'd0, b_pool_valid}, (i == 3) ? 32'd1 : 32'd0);
      check("b_done", {31'd0, b_frame_done}, (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) check("b_data", {16'd0, b_pool_data}, 32'd9);
    end
    @(negedge clk);
    b_valid = 1'b0;
    b_data  = 16'hABCD;
    @(posedge clk);
    #2;
    check("b_valid_after", {31'd0, b_pool_valid}, 32'd0);
    check("b_done_after", {31'd0, b_frame_done}, 32'd0);
    check("b_data_hold", {16'd0, b_pool_data}, 32'd9);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pool_unit.md
# pool_unit

Streaming 2x2/stride-2 max-pooling stage that sits directly downstream of the ReLU stage in the VGGNet conv datapath. It consumes one rectified FW-bit activation per valid cycle in row-major order for one IW x IH feature map. It emits one pooled activation per 2x2 window, (IW/2) x (IH/2) outputs per map, and flags the last output of each map. Horizontal pairs are reduced on the fly, and even-row partial maxima are held in an internal line buffer.

## Interface
Parameters:
- FW, 16, activation width; two's-complement signed.
- IW, 224, feature-map width in pixels; even, >= 2.
- IH, 224, feature-map height in pixels; even, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- relu_data_i  input  FW  activation from the ReLU stage.
- relu_valid_i  input  1  relu_data_i is valid this cycle; no backpressure, so every valid beat is consumed.
- pool_data_o  output  FW  pooled activation; registered.
- pool_valid_o  output  1  pool_data_o is valid; one-cycle pulse per output.
- frame_done_o  output  1  one-cycle pulse coincident with the last pooled output of a map.

## Operation
- Counters:
  - col counts 0..IW-1 and row counts 0..IH-1.
  - Both advance only on relu_valid_i.
  - col wraps to 0 at IW-1, and row increments on that wrap.
  - row wraps to 0 after row IH-1, col IW-1, so back-to-back maps need no idle cycle.
- Even col (col[0]=0): store relu_data_i in the pair register.
- Odd col: h = signed max(pair register, relu_data_i).
  - Even row: write h to line buffer entry col>>1. The buffer has IW/2 entries of FW bits.
  - Odd row: output signed max(line buffer entry col>>1, h).
- All comparisons are signed. On ties either operand may be selected, since the values are equal.
- Invalid cycles (relu_valid_i=0) change no state; gaps of any length are allowed at any position.
- The line buffer is not cleared between maps. Every entry is rewritten on an even row before it is read on an odd row.
- frame_done_o is asserted with the output produced by row IH-1, col IW-1.

## Timing
- Reset values:
  - pool_data_o=0, pool_valid_o=0, frame_done_o=0.
  - col=0, row=0, pair register=0.
  - Line buffer contents don't-care; they need no reset.
- Latency: pool_valid_o rises in the cycle after the clock edge that samples the odd-row, odd-col beat (1 cycle, registered output).
- pool_data_o holds its last value when pool_valid_o=0.
- Maximum throughput: one output per 4 input beats averaged; outputs only appear during odd rows, at most one every 2 cycles.
- Reset mid-map: the next valid beat after rst deasserts is treated as row 0, col 0. The partial map is discarded with no output or frame_done_o pulse. A pool_valid_o already scheduled for the reset cycle is cleared.
- A reset asserted while rst is high keeps all outputs at 0 regardless of relu_valid_i.

## Test plan
- IW=IH=4, inputs 0..15 continuous -> pool_valid_o pulses 4 times with values 5, 7, 13, 15; frame_done_o only with 15.
- Same stimulus with relu_valid_i randomly deasserted about 50% of cycles -> identical output sequence and frame_done_o placement; each output is exactly 1 cycle after its triggering beat.
- IW=IH=4, one window containing -1, -3, -7, -2 and others 0 -> that window yields 0xFFFF (-1, FW=16), confirming the signed compare.
- IW=IH=4, two maps back-to-back (0..15 then 15..0) -> outputs 5, 7, 13, 15, 15, 13, 7, 5, with frame_done_o on the 4th and 8th outputs.
- IW=IH=4, assert rst after 6 beats, then send 0..15 -> exactly 4 outputs 5, 7, 13, 15; no output from the aborted map.
- IW=2, IH=2, inputs 9, 3, 4, 8 -> single output 9 with pool_valid_o and frame_done_o high together.
